// File: rtl/psubsb_pkg.sv
// Shared types and constants for the serial packed saturating subtract unit.
package psubsb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_N_LANES = 4;
  localparam int DEF_LANE_W  = 4;
  localparam int CNT_W       = $clog2(DEF_N_LANES);

  localparam logic [DEF_LANE_W-1:0] SAT_MAX = 4'h7;
  localparam logic [DEF_LANE_W-1:0] SAT_MIN = 4'h8;

endpackage

// File: rtl/sat_lane_sub.sv
// One signed lane of saturating subtract (or add when PSUBSB_ADD_MODE_EN is defined).
module sat_lane_sub
  import psubsb_pkg::*;
#(
  parameter int LANE_W = DEF_LANE_W
) (
  input  logic [LANE_W-1:0] a,
  input  logic [LANE_W-1:0] b,
`ifdef PSUBSB_ADD_MODE_EN
  input  logic              op_add,
`endif
  output logic [LANE_W-1:0] result,
  output logic              ovfl
);

  logic [LANE_W-1:0] b_eff;
  logic [LANE_W-1:0] raw;
  logic              carry_in;

  // Subtract is a + ~b + 1, so one adder serves both operations.
`ifdef PSUBSB_ADD_MODE_EN
  assign b_eff    = op_add ? b : ~b;
  assign carry_in = ~op_add;
`else
  assign b_eff    = ~b;
  assign carry_in = 1'b1;
`endif

  assign raw  = a + b_eff + LANE_W'(carry_in);
  assign ovfl = (a[LANE_W-1] == b_eff[LANE_W-1]) && (raw[LANE_W-1] != a[LANE_W-1]);

  // Clamp toward the sign of a: 0111.. when non-negative, 1000.. when negative.
  assign result = ovfl ? {a[LANE_W-1], {(LANE_W-1){~a[LANE_W-1]}}} : raw;

endmodule

// File: rtl/psubsb_serial.sv
// Serial packed saturating subtract: one lane per cycle, start/done handshake.
// Optional saturating-add mode is enabled by defining PSUBSB_ADD_MODE_EN.
module psubsb_serial
  import psubsb_pkg::*;
#(
  parameter int N_LANES = DEF_N_LANES,
  parameter int LANE_W  = DEF_LANE_W
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      start,
  input  logic [N_LANES*LANE_W-1:0] Rs,
  input  logic [N_LANES*LANE_W-1:0] Rt,
`ifdef PSUBSB_ADD_MODE_EN
  input  logic                      op_add,
`endif
  output logic                      busy,
  output logic                      done,
  output logic [N_LANES*LANE_W-1:0] Rd,
  output logic [N_LANES-1:0]        Ovfl
);

  localparam int DATA_W = N_LANES * LANE_W;
  localparam int LCNT_W = $clog2(N_LANES);

  state_t              state_reg, state_next;
  logic [LCNT_W-1:0]   cnt_reg, cnt_next;
  logic [DATA_W-1:0]   rs_reg, rs_next;
  logic [DATA_W-1:0]   rt_reg, rt_next;
  logic [DATA_W-1:0]   rd_reg, rd_next;
  logic [N_LANES-1:0]  ovfl_reg, ovfl_next;
`ifdef PSUBSB_ADD_MODE_EN
  logic                op_add_reg, op_add_next;
`endif

  logic [LANE_W-1:0]   rs_lane [N_LANES];
  logic [LANE_W-1:0]   rt_lane [N_LANES];
  logic [N_LANES-1:0]  lane_sel;
  logic [LANE_W-1:0]   lane_res;
  logic                lane_ovfl;

  for (genvar gi = 0; gi < N_LANES; gi++) begin : g_lane
    assign rs_lane[gi]  = rs_reg[gi*LANE_W +: LANE_W];
    assign rt_lane[gi]  = rt_reg[gi*LANE_W +: LANE_W];
    assign lane_sel[gi] = (cnt_reg == LCNT_W'(gi));
  end

  // A single lane datapath, time-shared across lanes by the counter.
  sat_lane_sub #(.LANE_W(LANE_W)) u_lane (
    .a      (rs_lane[cnt_reg]),
    .b      (rt_lane[cnt_reg]),
`ifdef PSUBSB_ADD_MODE_EN
    .op_add (op_add_reg),
`endif
    .result (lane_res),
    .ovfl   (lane_ovfl)
  );

  always_comb begin
    state_next = state_reg;
    cnt_next   = cnt_reg;
    rs_next    = rs_reg;
    rt_next    = rt_reg;
    rd_next    = rd_reg;
    ovfl_next  = ovfl_reg;
`ifdef PSUBSB_ADD_MODE_EN
    op_add_next = op_add_reg;
`endif
    case (state_reg)
      IDLE, DONE: begin
        if (start) begin
          rs_next    = Rs;
          rt_next    = Rt;
          rd_next    = '0;
          ovfl_next  = '0;
          cnt_next   = '0;
`ifdef PSUBSB_ADD_MODE_EN
          op_add_next = op_add;
`endif
          state_next = RUN;
        end else begin
          state_next = IDLE;
        end
      end
      RUN: begin
        for (int i = 0; i < N_LANES; i++) begin
          if (lane_sel[i]) begin
            rd_next[i*LANE_W +: LANE_W] = lane_res;
            ovfl_next[i]                = lane_ovfl;
          end
        end
        if (cnt_reg == LCNT_W'(N_LANES - 1)) begin
          state_next = DONE;
        end else begin
          cnt_next = cnt_reg + 1'b1;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg <= IDLE;
      cnt_reg   <= '0;
      rs_reg    <= '0;
      rt_reg    <= '0;
      rd_reg    <= '0;
      ovfl_reg  <= '0;
`ifdef PSUBSB_ADD_MODE_EN
      op_add_reg <= 1'b0;
`endif
    end else begin
      state_reg <= state_next;
      cnt_reg   <= cnt_next;
      rs_reg    <= rs_next;
      rt_reg    <= rt_next;
      rd_reg    <= rd_next;
      ovfl_reg  <= ovfl_next;
`ifdef PSUBSB_ADD_MODE_EN
      op_add_reg <= op_add_next;
`endif
    end
  end

  assign busy = (state_reg == RUN);
  assign done = (state_reg == DONE);
  assign Rd   = rd_reg;
  assign Ovfl = ovfl_reg;

endmodule

// File: tb/tb_psubsb_serial.sv
// Self-checking bench for psubsb_serial: vector table, corner sequences, random vs model.
module tb_psubsb_serial;

  logic        clk;
  logic        rst;
  logic        start;
  logic [15:0] Rs;
  logic [15:0] Rt;
`ifdef PSUBSB_ADD_MODE_EN
  logic        op_add;
`endif
  logic        busy;
  logic        done;
  logic [15:0] Rd;
  logic [3:0]  Ovfl;

  int pass_cnt  = 0;
  int total_cnt = 0;

  psubsb_serial dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .Rs    (Rs),
    .Rt    (Rt),
`ifdef PSUBSB_ADD_MODE_EN
    .op_add(op_add),
`endif
    .busy  (busy),
    .done  (done),
    .Rd    (Rd),
    .Ovfl  (Ovfl)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  typedef struct {
    logic [15:0] rs;
    logic [15:0] rt;
    logic [15:0] rd;
    logic [3:0]  ov;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Reference: each lane as a signed integer, exact result clamped to [-8, 7].
  task automatic model(input logic [15:0] rs, input logic [15:0] rt, input logic add,
                       output logic [15:0] rd, output logic [3:0] ov);
    logic signed [3:0] la, lb;
    int r;
    rd = '0;
    ov = '0;
    for (int k = 0; k < 4; k++) begin
      la = rs[4*k +: 4];
      lb = rt[4*k +: 4];
      r  = add ? (int'(la) + int'(lb)) : (int'(la) - int'(lb));
      if (r > 7) begin
        rd[4*k +: 4] = 4'h7;
        ov[k] = 1'b1;
      end else if (r < -8) begin
        rd[4*k +: 4] = 4'h8;
        ov[k] = 1'b1;
      end else begin
        rd[4*k +: 4] = 4'(r);
      end
    end
  endtask

  // Issue one op from idle and wait (bounded) for done; checks latency, busy span and result.
  task automatic run_op(input string tag, input logic [15:0] rs, input logic [15:0] rt,
                        input logic add, input logic [15:0] exp_rd, input logic [3:0] exp_ov);
    int cycles;
    int busy_cnt;
    @(negedge clk);
    Rs = rs;
    Rt = rt;
`ifdef PSUBSB_ADD_MODE_EN
    op_add = add;
`else
    if (add) $display("note: add mode requested in subtract-only build");
`endif
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cycles = 1;
    busy_cnt = 0;
    while (!done && cycles < 20) begin
      if (busy) busy_cnt++;
      @(negedge clk);
      cycles++;
    end
    check({tag, " latency"}, cycles, 5);
    check({tag, " busy_cycles"}, busy_cnt, 4);
    check({tag, " Rd"}, Rd, exp_rd);
    check({tag, " Ovfl"}, Ovfl, exp_ov);
    $display("op %s: Rs=%h Rt=%h add=%0d -> Rd=%h Ovfl=%b", tag, rs, rt, add, Rd, Ovfl);
  endtask

  initial begin
    logic [15:0] mrd, held_rd, rrs, rrt;
    logic [3:0]  mov, held_ov;
    int cycles;
    int done_seen;

    vecs[0] = '{16'h7654, 16'h1111, 16'h6543, 4'b0000};
    vecs[1] = '{16'h8F70, 16'h1081, 16'h8F7F, 4'b1010};
    vecs[2] = '{16'h8888, 16'h7777, 16'h8888, 4'b1111};
    vecs[3] = '{16'h7777, 16'h8888, 16'h7777, 4'b1111};
    vecs[4] = '{16'h0000, 16'h8888, 16'h7777, 4'b1111};
    vecs[5] = '{16'hFFFF, 16'h7777, 16'h8888, 4'b0000};
    vecs[6] = '{16'h1234, 16'h1234, 16'h0000, 4'b0000};
    vecs[7] = '{16'h0000, 16'h0001, 16'h000F, 4'b0000};

    rst = 1'b1;
    start = 1'b0;
    Rs = '0;
    Rt = '0;
`ifdef PSUBSB_ADD_MODE_EN
    op_add = 1'b0;
`endif
    repeat (3) @(negedge clk);
    check("reset busy", busy, 0);
    check("reset done", done, 0);
    check("reset Rd", Rd, 0);
    check("reset Ovfl", Ovfl, 0);
    rst = 1'b0;

    for (int i = 0; i < 8; i++)
      run_op($sformatf("vec%0d", i), vecs[i].rs, vecs[i].rt, 1'b0, vecs[i].rd, vecs[i].ov);

    // done is a single-cycle pulse
    @(negedge clk);
    check("done single pulse", done, 0);

    // Hold: inputs change without start, results stay put.
    held_rd = Rd;
    held_ov = Ovfl;
    Rs = 16'hABCD;
    Rt = 16'h1357;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check("hold Rd", Rd, held_rd);
      check("hold Ovfl", Ovfl, held_ov);
    end
    $display("op hold: Rd=%h Ovfl=%b after 10 idle cycles", Rd, Ovfl);

    // Start held high: starts during RUN ignored, new op accepted in the DONE cycle.
    @(negedge clk);
    Rs = 16'h0000;
    Rt = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    Rs = 16'h7654;
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b first latency", cycles, 5);
    check("b2b first Rd", Rd, 16'hFFFF);
    check("b2b first Ovfl", Ovfl, 4'b0000);
    $display("op b2b first: Rd=%h Ovfl=%b", Rd, Ovfl);
    @(negedge clk);
    start = 1'b0;
    check("b2b accepted in DONE", busy, 1);
    cycles = 1;
    while (!done && cycles < 20) begin
      @(negedge clk);
      cycles++;
    end
    check("b2b second latency", cycles, 5);
    check("b2b second Rd", Rd, 16'h6543);
    check("b2b second Ovfl", Ovfl, 4'b0000);
    $display("op b2b second: Rd=%h Ovfl=%b", Rd, Ovfl);

    // Reset two cycles after start aborts the op.
    @(negedge clk);
    Rs = 16'h7654;
    Rt = 16'h1111;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("midrst busy", busy, 0);
    check("midrst done", done, 0);
    check("midrst Rd", Rd, 0);
    check("midrst Ovfl", Ovfl, 0);
    done_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (done) done_seen++;
    end
    check("midrst no done", done_seen, 0);
    $display("op midrst: Rd=%h Ovfl=%b done_seen=%0d", Rd, Ovfl, done_seen);

`ifdef PSUBSB_ADD_MODE_EN
    run_op("add sat", 16'h7777, 16'h1111, 1'b1, 16'h7777, 4'b1111);
    run_op("add off", 16'h7777, 16'h1111, 1'b0, 16'h6666, 4'b0000);
    run_op("add neg", 16'h8888, 16'hFFFF, 1'b1, 16'h8888, 4'b1111);
`endif

    for (int i = 0; i < 40; i++) begin
      logic add;
      rrs = 16'($urandom);
      rrt = 16'($urandom);
`ifdef PSUBSB_ADD_MODE_EN
      add = 1'($urandom_range(0, 1));
`else
      add = 1'b0;
`endif
      model(rrs, rrt, add, mrd, mov);
      run_op($sformatf("rand%0d", i), rrs, rrt, add, mrd, mov);
    end

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
